// File: rtl/counter_sequencer.sv
// Push-button command sequencer for the board counter: synchronized key presses drive load,
// run/pause and single-step of a prescaled up/down count. Define DEBOUNCE_EN to debounce keys.
module counter_sequencer #(
   parameter int WIDTH     = 8,
   parameter int TICK_DIV  = 50_000_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_load_n,
   input  logic             key_run_n,
   input  logic             key_step_n,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             running,
   output logic             wrap
);
   localparam int PW     = $clog2(TICK_DIV);
   localparam int K_LOAD = 0;
   localparam int K_RUN  = 1;
   localparam int K_STEP = 2;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [2:0]       key_n;
   logic [2:0]       press;
   state_t           state_reg, state_next;
   logic [PW-1:0]    presc_reg, presc_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             tick_reg, tick_next;
   logic             wrap_reg, wrap_next;
   logic             update;

   if (TICK_DIV < 2 || DB_CYCLES < 1) begin : g_bad_params
      $error("counter_sequencer: TICK_DIV must be >= 2 and DB_CYCLES >= 1");
   end

   assign key_n = {key_step_n, key_run_n, key_load_n};

   for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic sync1_reg, sync2_reg, level, level_d_reg, press_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
         end else begin
            sync1_reg <= key_n[gi];
            sync2_reg <= sync1_reg;
         end
      end

`ifdef DEBOUNCE_EN
      localparam int DW = $clog2(DB_CYCLES + 1);
      logic [DW-1:0] db_cnt_reg;
      logic          db_level_reg;

      // Any return to the accepted level restarts the stability count.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            db_cnt_reg   <= '0;
            db_level_reg <= 1'b1;
         end else if (sync2_reg == db_level_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == DW'(DB_CYCLES - 1)) begin
            db_cnt_reg   <= '0;
            db_level_reg <= sync2_reg;
         end else begin
            db_cnt_reg <= db_cnt_reg + DW'(1);
         end
      end
      assign level = db_level_reg;
`else
      assign level = sync2_reg;
`endif

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            level_d_reg <= 1'b1;
            press_reg   <= 1'b0;
         end else begin
            level_d_reg <= level;
            press_reg   <= level_d_reg & ~level;
         end
      end
      assign press[gi] = press_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (!press[K_LOAD] && press[K_RUN])
         state_next = (state_reg == IDLE) ? RUN : IDLE;
   end

   // Priority load > run > step; a run press also beats a coincident prescaler terminal count.
   always_comb begin
      update     = 1'b0;
      presc_next = presc_reg;
      count_next = count_reg;
      tick_next  = 1'b0;
      wrap_next  = 1'b0;
      if (press[K_LOAD]) begin
         count_next = load_val;
         presc_next = '0;
      end else if (press[K_RUN]) begin
         presc_next = '0;
      end else if (state_reg == RUN) begin
         if (presc_reg == PW'(TICK_DIV - 1)) begin
            presc_next = '0;
            update     = 1'b1;
         end else begin
            presc_next = presc_reg + PW'(1);
         end
      end else if (press[K_STEP]) begin
         update = 1'b1;
      end
      if (update) begin
         tick_next = 1'b1;
         if (up) begin
            count_next = count_reg + WIDTH'(1);
            wrap_next  = &count_reg;
         end else begin
            count_next = count_reg - WIDTH'(1);
            wrap_next  = ~|count_reg;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_reg <= '0;
         count_reg <= '0;
         tick_reg  <= 1'b0;
         wrap_reg  <= 1'b0;
      end else begin
         presc_reg <= presc_next;
         count_reg <= count_next;
         tick_reg  <= tick_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign count   = count_reg;
   assign tick    = tick_reg;
   assign wrap    = wrap_reg;
   assign running = (state_reg == RUN);
endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed vector table, reset/debounce sequences
// and randomized key traffic checked every cycle against a press-schedule reference model.
`timescale 1ns/1ps
module tb_counter_sequencer;
   localparam int WIDTH     = 8;
   localparam int TICK_DIV  = 4;
   localparam int DB_CYCLES = 8;
   localparam int LAT       = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             key_load_n = 1'b1;
   logic             key_run_n  = 1'b1;
   logic             key_step_n = 1'b1;
   logic             up = 1'b1;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] count;
   logic             tick, running, wrap;

   counter_sequencer #(
      .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .key_load_n(key_load_n), .key_run_n(key_run_n), .key_step_n(key_step_n),
      .load_val(load_val), .up(up),
      .count(count), .tick(tick), .running(running), .wrap(wrap)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: counts the cycles spent in RUN and applies presses at their scheduled cycle.
   logic [7:0] m_count;
   bit         m_run, m_tick, m_wrap;
   int         m_phase;
   bit         ev_load[int];
   bit         ev_run[int];
   bit         ev_step[int];

   typedef struct {
      bit         ld, rn, st;
      logic [7:0] lv;
      bit         up;
      int         w;
      logic [7:0] exp_count;
      bit         exp_run;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_count = 8'h00; m_run = 0; m_tick = 0; m_wrap = 0; m_phase = 0;
      ev_load.delete(); ev_run.delete(); ev_step.delete();
   endtask

   task automatic model_update();
      m_tick = 1;
      if (up) begin
         m_wrap  = (m_count == 8'hFF);
         m_count = m_count + 8'd1;
      end else begin
         m_wrap  = (m_count == 8'h00);
         m_count = m_count - 8'd1;
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
      cyc++;
      if (rst) begin
         model_reset();
      end else begin
         m_tick = 0; m_wrap = 0;
         if (ev_load.exists(cyc)) begin
            m_count = load_val; m_phase = 0;
         end else if (ev_run.exists(cyc)) begin
            m_run = !m_run; m_phase = 0;
         end else if (m_run) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
               m_phase = 0;
               model_update();
            end
         end else if (ev_step.exists(cyc)) begin
            model_update();
         end
      end
      @(negedge clk);
      chk("count", int'(count), int'(m_count));
      chk("running", int'(running), int'(m_run));
      chk("tick", int'(tick), int'(m_tick));
      chk("wrap", int'(wrap), int'(m_wrap));
   endtask

   task automatic press_keys(input bit ld, input bit rn, input bit st);
      if (ld) begin key_load_n = 1'b0; ev_load[cyc + LAT] = 1; end
      if (rn) begin key_run_n  = 1'b0; ev_run[cyc + LAT]  = 1; end
      if (st) begin key_step_n = 1'b0; ev_step[cyc + LAT] = 1; end
   endtask

   task automatic release_keys();
      key_load_n = 1'b1; key_run_n = 1'b1; key_step_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) step_cycle();
      rst = 1'b0;

`ifdef DEBOUNCE_EN
      load_val = 8'h3C;
      for (int k = 0; k < 10; k++) begin
         key_load_n = (k % 2 == 0) ? 1'b0 : 1'b1;
         repeat (3) begin
            @(negedge clk);
            chk("db_bounce_count", int'(count), 0);
         end
      end
      key_load_n = 1'b0;
      for (int k = 1; k <= DB_CYCLES + 4; k++) begin
         @(negedge clk);
         chk("db_load_count", int'(count), (k == DB_CYCLES + 4) ? 32'h3C : 0);
         chk("db_tick", int'(tick), 0);
      end
      load_val = 8'hC3;
      repeat (20) begin
         @(negedge clk);
         chk("db_single_load", int'(count), 32'h3C);
      end
      key_load_n = 1'b1;
`else
      //             ld rn st  lv     up  w  count  run
      vecs[0]  = '{1, 0, 0, 8'h2A, 1, 1, 8'h2A, 0};
      vecs[1]  = '{1, 0, 0, 8'hFE, 1, 1, 8'hFE, 0};
      vecs[2]  = '{0, 1, 0, 8'h00, 1, 8, 8'h00, 1};
      vecs[3]  = '{0, 1, 0, 8'h00, 1, 3, 8'h00, 0};
      vecs[4]  = '{0, 0, 1, 8'h00, 0, 2, 8'hFF, 0};
      vecs[5]  = '{0, 0, 1, 8'h00, 1, 1, 8'h00, 0};
      vecs[6]  = '{0, 0, 1, 8'h00, 1, 1, 8'h01, 0};
      vecs[7]  = '{1, 1, 0, 8'h55, 1, 2, 8'h55, 0};
      vecs[8]  = '{0, 1, 1, 8'h00, 1, 2, 8'h55, 1};
      vecs[9]  = '{0, 0, 1, 8'h00, 1, 1, 8'h56, 1};
      vecs[10] = '{1, 0, 0, 8'h10, 1, 3, 8'h10, 1};
      vecs[11] = '{0, 1, 0, 8'h00, 0, 2, 8'h0F, 0};
      for (int i = 0; i < 12; i++) begin
         up = vecs[i].up;
         if (vecs[i].ld) load_val = vecs[i].lv;
         press_keys(vecs[i].ld, vecs[i].rn, vecs[i].st);
         repeat (2) step_cycle();
         release_keys();
         repeat (LAT - 2 + vecs[i].w) step_cycle();
         chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].exp_count));
         chk($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].exp_run));
      end

      // Reset asserted between edges while a run tick is being shown.
      up = 1'b1; load_val = 8'h36;
      press_keys(1, 0, 0);
      repeat (2) step_cycle();
      release_keys();
      repeat (LAT) step_cycle();
      press_keys(0, 1, 0);
      repeat (2) step_cycle();
      release_keys();
      repeat (LAT - 2 + TICK_DIV) step_cycle();
      chk("pre_reset_count", int'(count), 32'h37);
      chk("pre_reset_tick", int'(tick), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_count", int'(count), 0);
      chk("async_reset_running", int'(running), 0);
      chk("async_reset_tick", int'(tick), 0);
      model_reset();
      repeat (2) step_cycle();
      rst = 1'b0;
      repeat (20) step_cycle();

      for (int i = 0; i < 250; i++) begin
         int c;
         bit ld, rn, st;
         c = $urandom_range(0, 6);
         ld = (c == 0) || (c == 4) || (c == 6);
         rn = (c == 1) || (c == 4) || (c == 5) || (c == 6);
         st = (c == 2) || (c == 3) || (c == 5) || (c == 6);
         up = 1'($urandom_range(0, 1));
         load_val = 8'($urandom);
         press_keys(ld, rn, st);
         repeat (2) step_cycle();
         release_keys();
         repeat ($urandom_range(3, 14)) begin
            if ($urandom_range(0, 7) == 0) up = ~up;
            step_cycle();
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
